// File: rtl/execute_stage.sv
// Execute stage: ARM condition check, data-processing ALU and registered writeback bundle.
// Define EXEC_MUL_EN to add the iterative shift-add MUL (otherwise MUL encodings retire illegal).
module execute_stage #(
    parameter int         M         = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instruction,
    input  logic [M-1:0] rd1,
    input  logic [M-1:0] rd2,
    output logic         wb_valid,
    output logic         wb_we3,
    output logic [3:0]   wb_a3,
    output logic [M-1:0] wb_wd3,
    output logic         wb_illegal,
    output logic [3:0]   flags
);
    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101
    } cmd_e;

    logic [3:0]   r_flags;
    logic         r_wb_valid;
    logic         r_wb_we3;
    logic         r_wb_illegal;
    logic [3:0]   r_wb_a3;
    logic [M-1:0] r_wb_wd3;

    logic         w_n, w_z, w_c, w_v;
    logic         w_pass;
    logic         w_accept;
    logic         w_is_mul_enc;
    logic         w_cmd_ok;
    logic         w_dp_illegal;
    logic         w_illegal;
    logic         w_writes;
    logic         w_upd_flags;
    logic [3:0]   w_cmd;
    logic [3:0]   w_rd;
    logic [4:0]   w_rot;
    logic [M-1:0] w_imm;
    logic [M-1:0] w_opb;
    logic [M:0]   w_add;
    logic [M:0]   w_sub;
    logic [M-1:0] w_res;
    logic [3:0]   w_flags_nxt;
    logic         w_mul_start;
    logic         w_mul_done;
    logic         w_mul_s;
    logic [3:0]   w_mul_rd;
    logic [M-1:0] w_mul_res;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_accept     = in_valid && in_ready;
    assign w_cmd        = instruction[24:21];
    assign w_is_mul_enc = (instruction[27:22] == 6'b000000) && (instruction[7:4] == 4'b1001);
    assign w_rd         = w_is_mul_enc ? instruction[19:16] : instruction[15:12];
    assign w_writes     = (w_cmd != CMD_CMP);
    assign w_upd_flags  = instruction[20] || (w_cmd == CMD_CMP);

    always_comb begin
        w_pass = 1'b0;
        case (instruction[31:28])
            4'h0: w_pass = w_z;
            4'h1: w_pass = !w_z;
            4'h2: w_pass = w_c;
            4'h3: w_pass = !w_c;
            4'h4: w_pass = w_n;
            4'h5: w_pass = !w_n;
            4'h6: w_pass = w_v;
            4'h7: w_pass = !w_v;
            4'h8: w_pass = w_c && !w_z;
            4'h9: w_pass = !w_c || w_z;
            4'hA: w_pass = (w_n == w_v);
            4'hB: w_pass = (w_n != w_v);
            4'hC: w_pass = !w_z && (w_n == w_v);
            4'hD: w_pass = w_z || (w_n != w_v);
            4'hE: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_cmd_ok = 1'b0;
        case (w_cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: w_cmd_ok = 1'b1;
            default: w_cmd_ok = 1'b0;
        endcase
    end

    assign w_dp_illegal = (instruction[27:26] != 2'b00) || !w_cmd_ok ||
                          (w_writes && (instruction[15:12] == 4'hF));

    // Shift-amount of M on a zero rotation yields 0, so the OR degenerates to the plain immediate.
    assign w_rot = {instruction[11:8], 1'b0};
    assign w_imm = {{(M-8){1'b0}}, instruction[7:0]};
    assign w_opb = instruction[25] ? ((w_imm >> w_rot) | (w_imm << (7'(M) - 7'(w_rot)))) : rd2;

    assign w_add = {1'b0, rd1} + {1'b0, w_opb};
    assign w_sub = {1'b0, rd1} + {1'b0, ~w_opb} + {{M{1'b0}}, 1'b1};

    always_comb begin
        w_res       = '0;
        w_flags_nxt = r_flags;
        case (w_cmd)
            CMD_AND: w_res = rd1 & w_opb;
            CMD_ORR: w_res = rd1 | w_opb;
            CMD_MOV: w_res = w_opb;
            CMD_ADD: begin
                w_res          = w_add[M-1:0];
                w_flags_nxt[1] = w_add[M];
                w_flags_nxt[0] = (rd1[M-1] == w_opb[M-1]) && (w_add[M-1] != rd1[M-1]);
            end
            CMD_SUB, CMD_CMP: begin
                w_res          = w_sub[M-1:0];
                w_flags_nxt[1] = w_sub[M];
                w_flags_nxt[0] = (rd1[M-1] != w_opb[M-1]) && (w_sub[M-1] != rd1[M-1]);
            end
            default: w_res = '0;
        endcase
        w_flags_nxt[3] = w_res[M-1];
        w_flags_nxt[2] = (w_res == '0);
    end

`ifdef EXEC_MUL_EN
    typedef enum logic {IDLE, MUL_BUSY} state_e;
    localparam int CW = $clog2(M);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_mcand;
    logic [M-1:0]  r_mplier;
    logic [M-1:0]  r_acc;
    logic [3:0]    r_mul_rd;
    logic          r_mul_s;

    assign w_illegal   = w_is_mul_enc ? (instruction[19:16] == 4'hF) : w_dp_illegal;
    assign w_mul_start = w_accept && w_is_mul_enc && !w_illegal && w_pass;
    assign w_mul_done  = (r_state == MUL_BUSY) && (r_cnt == CW'(M-1));
    assign w_mul_res   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_rd    = r_mul_rd;
    assign w_mul_s     = r_mul_s;
    assign in_ready    = (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_mul_start) w_state_nxt = MUL_BUSY;
            MUL_BUSY: if (r_cnt == CW'(M-1)) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mul_rd <= '0;
            r_mul_s  <= 1'b0;
        end else if (w_mul_start) begin
            r_cnt    <= '0;
            r_mcand  <= rd1;
            r_mplier <= rd2;
            r_acc    <= '0;
            r_mul_rd <= w_rd;
            r_mul_s  <= instruction[20];
        end else if (r_state == MUL_BUSY) begin
            r_cnt    <= r_cnt + CW'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_mul_res;
        end
    end
`else
    assign w_illegal   = w_is_mul_enc || w_dp_illegal;
    assign w_mul_start = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_mul_res   = '0;
    assign w_mul_rd    = '0;
    assign w_mul_s     = 1'b0;
    assign in_ready    = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags      <= FLAGS_RST;
            r_wb_valid   <= 1'b0;
            r_wb_we3     <= 1'b0;
            r_wb_illegal <= 1'b0;
            r_wb_a3      <= '0;
            r_wb_wd3     <= '0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_wb_we3     <= 1'b0;
            r_wb_illegal <= 1'b0;
            if (w_mul_done) begin
                r_wb_valid <= 1'b1;
                r_wb_we3   <= 1'b1;
                r_wb_a3    <= w_mul_rd;
                r_wb_wd3   <= w_mul_res;
                if (w_mul_s) r_flags[3:2] <= {w_mul_res[M-1], (w_mul_res == '0)};
            end else if (w_accept && !w_mul_start) begin
                r_wb_valid   <= 1'b1;
                r_wb_illegal <= w_illegal;
                r_wb_we3     <= !w_illegal && w_pass && w_writes;
                r_wb_a3      <= w_rd;
                r_wb_wd3     <= w_res;
                if (!w_illegal && w_pass && w_upd_flags) r_flags <= w_flags_nxt;
            end
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_we3     = r_wb_we3;
    assign wb_illegal = r_wb_illegal;
    assign wb_a3      = r_wb_a3;
    assign wb_wd3     = r_wb_wd3;
    assign flags      = r_flags;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed and random instructions checked against an
// architectural model; build with EXEC_MUL_EN to match a DUT built with the multiplier.
module tb_execute_stage;
    localparam int         M         = 32;
    localparam logic [3:0] FLAGS_RST = 4'b0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instruction;
    logic [M-1:0] rd1;
    logic [M-1:0] rd2;
    logic         wb_valid;
    logic         wb_we3;
    logic [3:0]   wb_a3;
    logic [M-1:0] wb_wd3;
    logic         wb_illegal;
    logic [3:0]   flags;

    execute_stage #(.M(M), .FLAGS_RST(FLAGS_RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_valid   (wb_valid),
        .wb_we3     (wb_we3),
        .wb_a3      (wb_a3),
        .wb_wd3     (wb_wd3),
        .wb_illegal (wb_illegal),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we3;
        logic        ill;
        logic [3:0]  a3;
        logic [31:0] wd;
        logic [3:0]  fl;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [3:0]  m_flags;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural effect of one accepted instruction; pushes the expected retire record.
    task automatic model_issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [3:0]  cmd;
        logic [3:0]  nf;
        logic [31:0] opb;
        logic [31:0] res;
        longint      sd;
        bit          pass;
        bit          mul_enc;
        cmd     = ins[24:21];
        pass    = cond_holds(ins[31:28], m_flags);
        mul_enc = (ins[27:22] == 6'd0) && (ins[7:4] == 4'b1001);
        e.we3 = 1'b0;
        e.ill = 1'b0;
        e.a3  = ins[15:12];
        e.wd  = '0;
        e.cyc = cyc + 1;
        if (mul_enc) begin
            e.a3 = ins[19:16];
`ifdef EXEC_MUL_EN
            if (ins[19:16] == 4'hF) e.ill = 1'b1;
            else if (pass) begin
                e.we3 = 1'b1;
                e.wd  = a * b;
                e.cyc = cyc + 1 + M;
                if (ins[20]) begin
                    m_flags[3] = e.wd[31];
                    m_flags[2] = (e.wd == 0);
                end
            end
`else
            e.ill = 1'b1;
`endif
        end else begin
            opb = b;
            if (ins[25]) begin
                opb = {24'd0, ins[7:0]};
                repeat (2 * int'(ins[11:8])) opb = {opb[0], opb[31:1]};
            end
            if ((ins[27:26] != 2'b00) || !(cmd inside {4'h0, 4'h2, 4'h4, 4'hA, 4'hC, 4'hD}) ||
                ((cmd != 4'hA) && (ins[15:12] == 4'hF))) begin
                e.ill = 1'b1;
            end else if (pass) begin
                nf = m_flags;
                case (cmd)
                    4'h0: res = a & opb;
                    4'hC: res = a | opb;
                    4'hD: res = opb;
                    4'h4: begin
                        res   = a + opb;
                        nf[1] = (64'(a) + 64'(opb)) > 64'hFFFF_FFFF;
                        sd    = longint'($signed(a)) + longint'($signed(opb));
                        nf[0] = (sd != longint'($signed(res)));
                    end
                    default: begin
                        res   = a - opb;
                        nf[1] = (a >= opb);
                        sd    = longint'($signed(a)) - longint'($signed(opb));
                        nf[0] = (sd != longint'($signed(res)));
                    end
                endcase
                nf[3] = res[31];
                nf[2] = (res == 0);
                e.we3 = (cmd != 4'hA);
                e.wd  = res;
                if (ins[20] || (cmd == 4'hA)) m_flags = nf;
            end
        end
        e.fl = m_flags;
        q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int unsigned w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errs++;
            $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", w);
            return;
        end
        instruction = ins;
        rd1         = a;
        rd2         = b;
        in_valid    = 1'b1;
        model_issue(ins, a, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] gen_operand();
        logic [31:0] sp[5];
        sp = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [3:0]  cond;
        logic [3:0]  cmds[6];
        logic [3:0]  c;
        int unsigned kind;
        cmds = '{4'h0, 4'h2, 4'h4, 4'hA, 4'hC, 4'hD};
        cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        kind = $urandom_range(0, 19);
        if (kind == 0) return {cond, 2'($urandom_range(1, 3)), 26'($urandom)};
        if (kind == 1) begin
            c = 4'h0;
            while (c inside {4'h0, 4'h2, 4'h4, 4'hA, 4'hC, 4'hD}) c = 4'($urandom_range(0, 15));
            return {cond, 2'b00, 1'($urandom), c, 21'($urandom)};
        end
        if (kind <= 3) return {cond, 6'b000000, 2'($urandom), 12'($urandom), 4'b1001, 4'($urandom)};
        return {cond, 2'b00, 1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom), 20'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL spurious_wb: wb_valid=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("retire_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("wb_we3", 32'(wb_we3), 32'(mon_e.we3));
                chk("wb_illegal", 32'(wb_illegal), 32'(mon_e.ill));
                chk("flags", 32'(flags), 32'(mon_e.fl));
                if (mon_e.we3) begin
                    chk("wb_a3", 32'(wb_a3), 32'(mon_e.a3));
                    chk("wb_wd3", wb_wd3, mon_e.wd);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cnt;
        logic [31:0] ri, ra, rb;
        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = '0;
        rd1         = '0;
        rd2         = '0;
        m_flags     = FLAGS_RST;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we3", 32'(wb_we3), 32'd0);
        chk("rst_wb_a3", 32'(wb_a3), 32'd0);
        chk("rst_wb_wd3", wb_wd3, 32'd0);
        chk("rst_wb_illegal", 32'(wb_illegal), 32'd0);
        chk("rst_flags", 32'(flags), 32'(FLAGS_RST));
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        issue(32'hE2812005, 32'd10, 32'd0);
        issue(32'hE0513001, 32'd7, 32'd7);
        issue(32'h12812005, 32'd1, 32'd0);
        issue(32'hE3A004FF, 32'd0, 32'd0);
        issue(32'hE2910001, 32'h7FFF_FFFF, 32'd0);
        issue(32'hE0210002, 32'd5, 32'd3);
        issue(32'hE0030291, 32'd6, 32'd7);
`ifdef EXEC_MUL_EN
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 32'(cnt), 32'(M));
`else
        chk("in_ready_tied", 32'(in_ready), 32'd1);
`endif
        @(negedge clk);

        // Abort an in-flight multiply: nothing may retire and flags return to the reset value.
        issue(32'hE0050392, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_flags = FLAGS_RST;
        #1;
        chk("midop_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midop_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midop_rst_flags", 32'(flags), 32'(FLAGS_RST));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_flags", 32'(flags), 32'(FLAGS_RST));
        issue(32'hE2812005, 32'd10, 32'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            ri = gen_instr();
            ra = gen_operand();
            rb = ($urandom_range(0, 7) == 0) ? ra : gen_operand();
            issue(ri, ra, rb);
        end

        cnt = 0;
        while (q.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_outstanding", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
